// File: rtl/apb_slave_mem_responder.sv
// APB4 completer backed by a small byte-addressed memory.
// Programmable wait states, byte strobes, error response and abort detection.
module apb_slave_mem_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = '0,
    parameter int                       MEM_BYTES     = 64,
    parameter bit                       SECURE_ONLY   = 1'b0
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [3:0]                wait_states,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      protocol_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(NB - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_OFF   = ADDRESS_WIDTH'(MEM_BYTES - NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         strb_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  perr_q, perr_d;

    logic                  latch_en;
    logic                  mem_we;

    logic [7:0] mem [MEM_BYTES];

    logic setup_ph;
    logic access_ph;

    assign setup_ph  = psel & ~penable;
    assign access_ph = psel & penable;

    // Offset carries a borrow bit so "below window" needs no constant compare.
    logic [ADDRESS_WIDTH:0] off_ext;
    logic                   below;
    logic                   above;
    logic                   misalign;
    logic                   prot_err;
    logic                   addr_err;
    logic [IDX_W-1:0]       idx_in;

    assign off_ext  = {1'b0, paddr} - {1'b0, MIN_ADDRESS};
    assign below    = off_ext[ADDRESS_WIDTH];
    assign above    = off_ext[ADDRESS_WIDTH-1:0] > LAST_OFF;
    assign misalign = |(paddr & ALIGN_MASK);
    assign prot_err = SECURE_ONLY & pprot[1];
    assign addr_err = misalign | below | above | prot_err;
    assign idx_in   = off_ext[IDX_W-1:0];

    logic unused_prot;
    assign unused_prot = pprot[0] ^ pprot[2];

    // Read data is taken from the live bus in IDLE, from the latch in WAIT.
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_idx = (state_q == S_IDLE) ? idx_in : idx_q;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NB; i++) begin
            rd_word[8*i +: 8] = mem[rd_idx + IDX_W'(i)];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        mem_we    = 1'b0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        perr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access_ph) begin
                    perr_d = 1'b1;
                end else if (setup_ph) begin
                    latch_en = 1'b1;
                    if (wait_states == 4'd0) begin
                        state_d   = S_COMPLETE;
                        pready_d  = 1'b1;
                        pslverr_d = addr_err;
                        if (!pwrite && !addr_err) begin
                            prdata_d = rd_word;
                        end
                    end else begin
                        cnt_d   = wait_states;
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (!access_ph) begin
                    perr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = S_COMPLETE;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        if (!write_q && !err_q) begin
                            prdata_d = rd_word;
                        end
                    end
                end
            end

            S_COMPLETE: begin
                state_d = S_IDLE;
                if (!access_ph) begin
                    perr_d = 1'b1;
                end else begin
                    mem_we = write_q & ~err_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            perr_q    <= perr_d;
            if (latch_en) begin
                idx_q   <= idx_in;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                err_q   <= addr_err;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q + IDX_W'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign prdata       = prdata_q;
    assign pready       = pready_q;
    assign pslverr      = pslverr_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Bench for apb_slave_mem_responder: vector table, corner sequences,
// and randomized transfers against a byte-array reference model.
module tb_apb_slave_mem_responder;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  ws;

    logic [31:0] prdata, prdata_s;
    logic        pready, pready_s;
    logic        pslverr, pslverr_s;
    logic        perr, perr_s;

    always #5 pclk = ~pclk;

    apb_slave_mem_responder u_dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .wait_states(ws), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .protocol_err(perr)
    );

    apb_slave_mem_responder #(.SECURE_ONLY(1'b1)) u_sec (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .wait_states(ws), .prdata(prdata_s), .pready(pready_s),
        .pslverr(pslverr_s), .protocol_err(perr_s)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference memories: [0] plain instance, [1] secure-only instance.
    logic [7:0] mm [2][64];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  p;
        logic [3:0]  wsv;
        logic [31:0] r0;
        logic [31:0] r1;
        logic        e0;
        logic        e1;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d,
                                logic [3:0] s, logic [2:0] p, logic [3:0] wsv,
                                logic [31:0] r0, logic [31:0] r1,
                                logic e0, logic e1);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.s = s; v.p = p; v.wsv = wsv;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; ws = '0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++)
                mm[k][i] = 8'h00;
    endtask

    task automatic model_xfer(input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [2:0] p,
                              output logic [31:0] r0, output logic [31:0] r1,
                              output logic e0, output logic e1);
        logic [31:0] r [2];
        logic        e [2];
        for (int k = 0; k < 2; k++) begin
            e[k] = (a % 4 != 0) || (a > 32'd60) || (k == 1 && p[1]);
            r[k] = '0;
            if (!e[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (!w)
                        r[k][8*b +: 8] = mm[k][int'(a) + b];
                    else if (s[b])
                        mm[k][int'(a) + b] = d[8*b +: 8];
                end
            end
        end
        r0 = r[0]; r1 = r[1]; e0 = e[0]; e1 = e[1];
    endtask

    // Drives one transfer starting now; returns at the cycle after completion
    // with the bus released, so a following call is back-to-back.
    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, input logic [3:0] wsv,
                        output logic [31:0] rd0, output logic [31:0] rd1,
                        output logic e0, output logic e1, output int low,
                        output logic rdy1, output logic pe);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a;
        pwdata = d; pstrb = s; pprot = p; ws = wsv;
        step();
        penable = 1'b1;
        ws = ~wsv;
        low = 0;
        pe = 1'b0;
        while (!pready && low < 40) begin
            pe = pe | perr | perr_s;
            step();
            low++;
        end
        rd0 = prdata; rd1 = prdata_s; e0 = pslverr; e1 = pslverr_s;
        rdy1 = pready_s;
        pe = pe | perr | perr_s;
        step();
        pe = pe | perr | perr_s;
        bus_idle();
    endtask

    task automatic run_check(input string nm, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p,
                             input logic [3:0] wsv);
        logic [31:0] x0, x1, g0, g1;
        logic        f0, f1, h0, h1, rdy1, pe;
        int          low;
        model_xfer(w, a, d, s, p, x0, x1, f0, f1);
        xfer(w, a, d, s, p, wsv, g0, g1, h0, h1, low, rdy1, pe);
        check({nm, "_rdata"}, g0, x0);
        check({nm, "_rdata_sec"}, g1, x1);
        check({nm, "_slverr"}, 32'(h0), 32'(f0));
        check({nm, "_slverr_sec"}, 32'(h1), 32'(f1));
        check({nm, "_wait_cycles"}, 32'(low), 32'(wsv));
        check({nm, "_ready_sec"}, 32'(rdy1), 32'd1);
        check({nm, "_protocol_err"}, 32'(pe), 32'd0);
    endtask

    initial begin
        logic [31:0] g0, g1, m0, m1;
        logic        h0, h1, f0, f1, rdy1, pe;
        int          low;

        vt[0]  = mk(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 4'd0, 0, 0, 0, 0);
        vt[1]  = mk(0, 32'h10, 0, 4'h0, 3'b000, 4'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
        vt[2]  = mk(1, 32'h20, 32'h1122_3344, 4'b0101, 3'b000, 4'd0, 0, 0, 0, 0);
        vt[3]  = mk(0, 32'h20, 0, 4'h0, 3'b000, 4'd0, 32'h0022_0044, 32'h0022_0044, 0, 0);
        vt[4]  = mk(0, 32'h08, 0, 4'h0, 3'b000, 4'd3, 0, 0, 0, 0);
        vt[5]  = mk(0, 32'h08, 0, 4'h0, 3'b000, 4'd15, 0, 0, 0, 0);
        vt[6]  = mk(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 3'b000, 4'd1, 0, 0, 1, 1);
        vt[7]  = mk(0, 32'h3C, 0, 4'h0, 3'b000, 4'd0, 0, 0, 0, 0);
        vt[8]  = mk(1, 32'h02, 32'hFFFF_FFFF, 4'hF, 3'b000, 4'd0, 0, 0, 1, 1);
        vt[9]  = mk(0, 32'h00, 0, 4'h0, 3'b000, 4'd0, 0, 0, 0, 0);
        vt[10] = mk(1, 32'h0C, 32'hCAFE_F00D, 4'hF, 3'b010, 4'd2, 0, 0, 0, 1);
        vt[11] = mk(0, 32'h0C, 0, 4'h0, 3'b000, 4'd0, 32'hCAFE_F00D, 0, 0, 0);
        vt[12] = mk(1, 32'h10, 32'h1234_5678, 4'h0, 3'b000, 4'd0, 0, 0, 0, 0);
        vt[13] = mk(0, 32'h10, 0, 4'h0, 3'b000, 4'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
        vt[14] = mk(1, 32'h3C, 32'h8765_4321, 4'hF, 3'b000, 4'd1, 0, 0, 0, 0);
        vt[15] = mk(0, 32'h3C, 0, 4'h0, 3'b000, 4'd0, 32'h8765_4321, 32'h8765_4321, 0, 0);
        vt[16] = mk(1, 32'h30, 32'hA5A5_A5A5, 4'hF, 3'b000, 4'd0, 0, 0, 0, 0);
        vt[17] = mk(0, 32'h30, 0, 4'h0, 3'b000, 4'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0);
        vt[18] = mk(0, 32'h40, 0, 4'h0, 3'b000, 4'd0, 0, 0, 1, 1);
        vt[19] = mk(0, 32'h0C, 0, 4'h0, 3'b010, 4'd0, 32'hCAFE_F00D, 0, 0, 1);

        bus_idle();
        model_clear();
        preset = 1'b1;
        step(); step(); step();
        preset = 1'b0;
        step();
        check("reset_prdata", prdata, 32'h0);
        check("reset_pready", 32'(pready), 32'd0);
        check("reset_pslverr", 32'(pslverr), 32'd0);
        check("reset_protocol_err", 32'(perr), 32'd0);

        for (int i = 0; i < 20; i++) begin
            model_xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].p, m0, m1, f0, f1);
            xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].p, vt[i].wsv,
                 g0, g1, h0, h1, low, rdy1, pe);
            check($sformatf("vec%0d_rdata", i), g0, vt[i].r0);
            check($sformatf("vec%0d_rdata_sec", i), g1, vt[i].r1);
            check($sformatf("vec%0d_slverr", i), 32'(h0), 32'(vt[i].e0));
            check($sformatf("vec%0d_slverr_sec", i), 32'(h1), 32'(vt[i].e1));
            check($sformatf("vec%0d_wait_cycles", i), 32'(low), 32'(vt[i].wsv));
            check($sformatf("vec%0d_protocol_err", i), 32'(pe), 32'd0);
        end

        // Master drops psel in the middle of a wait-stated write.
        step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14;
        pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; ws = 4'd5;
        step();
        penable = 1'b1;
        step();
        step();
        check("abort_pready_low", 32'(pready), 32'd0);
        bus_idle();
        step();
        check("abort_protocol_err", 32'(perr), 32'd1);
        check("abort_protocol_err_sec", 32'(perr_s), 32'd1);
        check("abort_pready", 32'(pready), 32'd0);
        step();
        check("abort_pulse_end", 32'(perr), 32'd0);
        run_check("after_abort_read", 1'b0, 32'h14, 0, 4'h0, 3'b000, 4'd0);

        // Access phase with no preceding setup phase.
        psel = 1'b1; penable = 1'b1;
        step();
        bus_idle();
        check("idle_violation_err", 32'(perr), 32'd1);
        check("idle_violation_ready", 32'(pready), 32'd0);
        step();
        check("idle_violation_end", 32'(perr), 32'd0);

        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) < 8)
                a = 32'($urandom_range(0, 15)) * 4;
            else
                a = 32'($urandom_range(0, 71));
            run_check($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a,
                      $urandom, 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0)
                step();
        end

        // Reset while a write sits in WAIT: no write, memory cleared.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30;
        pwdata = 32'h5A5A_5A5A; pstrb = 4'hF; ws = 4'd5;
        step();
        penable = 1'b1;
        step();
        preset = 1'b1;
        step();
        check("midreset_prdata", prdata, 32'h0);
        check("midreset_pready", 32'(pready), 32'd0);
        check("midreset_pslverr", 32'(pslverr), 32'd0);
        check("midreset_protocol_err", 32'(perr), 32'd0);
        preset = 1'b0;
        bus_idle();
        model_clear();
        step();
        xfer(1'b0, 32'h10, 0, 4'h0, 3'b000, 4'd0, g0, g1, h0, h1, low, rdy1, pe);
        check("midreset_mem_0x10", g0, 32'h0);
        run_check("midreset_read_0x30", 1'b0, 32'h30, 0, 4'h0, 3'b000, 4'd2);
        run_check("midreset_read_0x3c", 1'b0, 32'h3C, 0, 4'h0, 3'b000, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem_responder.md
Name: apb_slave_mem_responder

Overview:
- Synthesizable APB4 completer (slave end) backed by a small byte-addressed memory.
- Answers transfers from the APB master agent or bridge.
- Supports programmable wait states, byte strobes, address-range and protection error response, and protocol-violation detection.
- Serves as the RTL DUT-side responder at one slave select of the APB environment.

Parameters:
ADDRESS_WIDTH, 32, width of paddr
DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32
MIN_ADDRESS, 32'h0000_0000, base address of the memory window
MEM_BYTES, 64, memory size in bytes; multiple of DATA_WIDTH/8
SECURE_ONLY, 0, 1 = reject non-secure accesses (pprot[1]=1) with pslverr

Ports:
pclk  in  1  APB clock; all logic on rising edge
preset  in  1  reset, synchronous, active-high
psel  in  1  slave select
penable  in  1  access-phase indicator
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDRESS_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte enables; ignored on reads
pprot  in  3  protection type
wait_states  in  4  number of access cycles with pready low (0-15), sampled in setup
prdata  out  DATA_WIDTH  read data, valid only while pready=1
pready  out  1  transfer completion
pslverr  out  1  error response, valid only while pready=1
protocol_err  out  1  one-cycle pulse on detected protocol violation

Behaviour:
- Reset (preset=1 at a clock edge):
  - State goes to IDLE.
  - prdata=0, pready=0, pslverr=0, protocol_err=0.
  - All memory bytes cleared to 0.
  - Reset mid-transfer aborts the transfer with no memory write.
- All outputs are registered.
- State IDLE: pready=0.
  - psel=1 and penable=0 (setup phase) latches paddr, pwrite, pwdata, pstrb, pprot and wait_states.
  - Error flag computed at latch time: err=1 if the address is not aligned to DATA_WIDTH/8; or address < MIN_ADDRESS; or address > MIN_ADDRESS+MEM_BYTES-DATA_WIDTH/8; or (SECURE_ONLY=1 and pprot[1]=1).
  - If wait_states=0, go to COMPLETE; otherwise load cnt=wait_states and go to WAIT.
  - psel=1 and penable=1 while in IDLE is a violation: pulse protocol_err and stay in IDLE.
- State WAIT: pready=0.
  - Each cycle with psel=1 and penable=1, cnt decrements; cnt reaching 0 goes to COMPLETE.
  - Result: exactly wait_states access cycles with pready low.
- State COMPLETE: pready=1 for exactly one cycle, pslverr=err.
  - Read with err=0: prdata = little-endian word of memory at index (paddr-MIN_ADDRESS); byte 0 on prdata[7:0].
  - Read with err=1: prdata=0.
  - Write with err=0: at the end of this cycle, each byte i with pstrb[i]=1 takes pwdata[8i+7:8i]; other bytes unchanged.
  - pstrb=0 is legal: no change to memory, pslverr=0.
  - Write with err=1: memory unchanged.
  - Next state is IDLE; outputs pready, pslverr and prdata return to 0.
- prdata for COMPLETE is registered on the transition into COMPLETE. Memory state at that point must include any write committed in an earlier COMPLETE, so back-to-back write then read of the same word returns the new data.
- Abort: in WAIT or COMPLETE, psel=0 or penable=0 (master dropped the transfer):
  - Pulse protocol_err.
  - No memory write.
  - Return to IDLE with outputs zeroed.
- Back-to-back transfers: a setup phase in the cycle right after COMPLETE is accepted normally from IDLE.
- A write transfer never changes prdata.
- Latched fields are held constant for the whole transfer, even if inputs change (this is checked by protocol_err only for psel and penable).

Test Plan:
1. Reset, then write 32'hDEAD_BEEF to 0x10 with pstrb=4'hF, wait_states=0; read 0x10 -> write completes in the first access cycle; read returns 32'hDEAD_BEEF, pslverr=0.
2. Write 32'h1122_3344 to 0x20 with pstrb=4'b0101 over memory of 0 -> read returns 32'h0022_0044.
3. Read 0x08 with wait_states=3 -> pready low for 3 access cycles, high on the 4th, prdata=0; repeat with wait_states=15 -> 15 low cycles.
4. Error responses, each with memory unchanged:
   - Write to 0x40 (MEM_BYTES=64) -> pslverr=1 with pready=1.
   - Write to misaligned 0x02 -> pslverr=1.
   - SECURE_ONLY=1 with pprot=3'b010 -> pslverr=1.
5. Drop psel during WAIT with wait_states=5 on a write -> protocol_err pulses 1 cycle, no write, next transfer proceeds normally. Assert preset during WAIT -> all outputs 0 and memory all zero on the next read.
6. Back-to-back write 32'hA5A5_A5A5 to 0x30 then read 0x30 with no idle cycle -> read returns 32'hA5A5_A5A5.
